// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - round-robin arbiter and transaction sequencer for a shared I2C master
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   req        level request per client, held until its req_done
//   grant      registered one-hot grant, zero when the bus is free
//   owner      index of the granted client (mux select), holds last owner when idle
//   txn_start  one-cycle start pulse to the I2C master
//   txn_done   one-cycle completion pulse from the I2C master
//   req_done   one-hot one-cycle pulse to the owner at transaction end
//   req_err    one-cycle pulse alongside req_done when the end was a watchdog timeout
//   busy       high in any state other than IDLE
module i2c_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 600,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         owner,
    output logic               txn_start,
    input  logic               txn_done,
    output logic [NUM_REQ-1:0] req_done,
    output logic               req_err,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);
    localparam logic [31:0]        GAP_LAST = 32'(GAP_CYCLES - 1);
    localparam logic [31:0]        TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    state_t             state, state_n;
    logic [NUM_REQ-1:0] grant_n, req_done_n;
    logic [2:0]         owner_n, winner;
    logic               txn_start_n, req_err_n;
    logic [31:0]        wd, wd_n, gap_cnt, gap_n;
    int                 pos;

    // Round-robin pick: scan offsets NUM_REQ down to 1 from the last owner so
    // the nearest requester after the owner is written last and wins.
    always_comb begin
        winner = owner;
        pos    = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            pos = (int'(owner) + i) % NUM_REQ;
            if ((req & (ONE << pos)) != '0) begin
                winner = 3'(pos);
            end
        end
    end

    always_comb begin
        state_n     = state;
        grant_n     = grant;
        owner_n     = owner;
        txn_start_n = 1'b0;
        req_done_n  = '0;
        req_err_n   = 1'b0;
        wd_n        = wd;
        gap_n       = gap_cnt;
        case (state)
            IDLE: begin
                if (req != '0) begin
                    grant_n     = ONE << winner;
                    owner_n     = winner;
                    txn_start_n = 1'b1;
                    state_n     = START;
                end
            end
            START: begin
                wd_n    = '0;
                state_n = WAIT;
            end
            WAIT: begin
                // Completion is checked before the watchdog so a coincident
                // done is reported as a clean finish.
                if (txn_done) begin
                    req_done_n = ONE << owner;
                    grant_n    = '0;
                    gap_n      = '0;
                    state_n    = GAP;
                end else if (TIMEOUT_CYCLES != 0 && wd == TO_LAST) begin
                    req_done_n = ONE << owner;
                    req_err_n  = 1'b1;
                    grant_n    = '0;
                    gap_n      = '0;
                    state_n    = GAP;
                end else begin
                    wd_n = wd + 32'd1;
                end
            end
            GAP: begin
                if (GAP_CYCLES == 0 || gap_cnt == GAP_LAST) begin
                    state_n = IDLE;
                end else begin
                    gap_n = gap_cnt + 32'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            owner     <= 3'(NUM_REQ - 1);
            txn_start <= 1'b0;
            req_done  <= '0;
            req_err   <= 1'b0;
            wd        <= '0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            owner     <= owner_n;
            txn_start <= txn_start_n;
            req_done  <= req_done_n;
            req_err   <= req_err_n;
            wd        <= wd_n;
            gap_cnt   <= gap_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - scoreboard bench for i2c_bus_arbiter
module tb_i2c_bus_arbiter;

    localparam int NUM_REQ = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [2:0]         owner;
    logic               txn_start;
    logic               txn_done;
    logic [NUM_REQ-1:0] req_done;
    logic               req_err;
    logic               busy;

    i2c_bus_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .owner     (owner),
        .txn_start (txn_start),
        .txn_done  (txn_done),
        .req_done  (req_done),
        .req_err   (req_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [1:0] grant; logic [2:0] owner; } start_t;
    typedef struct { int cyc; logic [1:0] done; logic err; } done_t;
    typedef struct { int cyc; logic [1:0] grant; logic [2:0] owner; logic busy; } state_t;

    start_t sq[$];
    done_t  dq[$];
    state_t tq[$];

    int   tests = 0;
    int   fails = 0;
    logic end_flag = 1'b0;

    task automatic exp_start(input int c, input logic [1:0] g, input logic [2:0] o);
        start_t e;
        e.cyc = c; e.grant = g; e.owner = o;
        sq.push_back(e);
    endtask

    task automatic exp_done(input int c, input logic [1:0] d, input logic err);
        done_t e;
        e.cyc = c; e.done = d; e.err = err;
        dq.push_back(e);
    endtask

    task automatic exp_state(input int c, input logic [1:0] g, input logic [2:0] o, input logic b);
        state_t e;
        e.cyc = c; e.grant = g; e.owner = o; e.busy = b;
        tq.push_back(e);
    endtask

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_done(input int c, input logic [1:0] d);
        go_to(c);
        exp_done(c + 1, d, 1'b0);
        txn_done = 1'b1;
        go_to(c + 1);
        txn_done = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: the only process that compares and counts.
    always @(negedge clk) begin
        start_t s;
        done_t  d;
        state_t t;
        if (cyc >= 3) begin
            if (txn_start) begin
                if (sq.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    s = sq.pop_front();
                    check("start_cycle", cyc, s.cyc);
                    check("start_grant", int'(grant), int'(s.grant));
                    check("start_owner", int'(owner), int'(s.owner));
                    check("start_busy", int'(busy), 1);
                end
            end else if (sq.size() != 0 && sq[0].cyc <= cyc) begin
                s = sq.pop_front();
                check("missing_start_at", cyc, s.cyc - 1000);
            end

            if (req_done != '0 || req_err) begin
                if (dq.size() == 0) begin
                    check("unexpected_done", int'(req_done), 0);
                end else begin
                    d = dq.pop_front();
                    check("done_cycle", cyc, d.cyc);
                    check("done_vec", int'(req_done), int'(d.done));
                    check("done_err", int'(req_err), int'(d.err));
                    check("done_grant", int'(grant), 0);
                end
            end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
                d = dq.pop_front();
                check("missing_done_at", cyc, d.cyc - 1000);
            end

            if (tq.size() != 0 && tq[0].cyc <= cyc) begin
                t = tq.pop_front();
                check("state_cycle", cyc, t.cyc);
                check("state_grant", int'(grant), int'(t.grant));
                check("state_owner", int'(owner), int'(t.owner));
                check("state_busy", int'(busy), int'(t.busy));
                check("state_start", int'(txn_start), 0);
            end

            if (end_flag || cyc > 2000) begin
                check("run_bound", int'(cyc > 2000), 0);
                check("start_queue_left", sq.size(), 0);
                check("done_queue_left", dq.size(), 0);
                check("state_queue_left", tq.size(), 0);
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    initial begin
        reset    = 1'b1;
        req      = '0;
        txn_done = 1'b0;
        exp_state(3, 2'b00, 3'd1, 1'b0);
        go_to(3);
        reset = 1'b0;

        // Single request from client 0, done after 9 WAIT cycles.
        go_to(10);
        req = 2'b01;
        exp_start(11, 2'b01, 3'd0);
        pulse_done(20, 2'b01);
        req = 2'b00;
        exp_state(22, 2'b00, 3'd0, 1'b1);
        exp_state(23, 2'b00, 3'd0, 1'b0);

        // Both requesting: alternate, next grant 4 cycles after each done.
        go_to(30);
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_start(31 + 9 * k, (k % 2 == 0) ? 2'b10 : 2'b01, (k % 2 == 0) ? 3'd1 : 3'd0);
            pulse_done(36 + 9 * k, (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        req = 2'b00;
        exp_state(66, 2'b00, 3'd0, 1'b0);

        // Watchdog timeout on client 1, then client 0 after the gap.
        go_to(70);
        req = 2'b10;
        exp_start(71, 2'b10, 3'd1);
        go_to(100);
        req = 2'b11;
        exp_done(122, 2'b10, 1'b1);
        exp_state(123, 2'b00, 3'd1, 1'b1);
        exp_state(124, 2'b00, 3'd1, 1'b0);
        go_to(122);
        req = 2'b01;
        exp_start(125, 2'b01, 3'd0);

        // Done during START is ignored; the later one completes.
        go_to(125);
        txn_done = 1'b1;
        go_to(126);
        txn_done = 1'b0;
        pulse_done(128, 2'b01);
        req = 2'b00;

        // Done coincides with watchdog expiry: clean finish.
        go_to(140);
        req = 2'b01;
        exp_start(141, 2'b01, 3'd0);
        pulse_done(191, 2'b01);
        req = 2'b00;

        // Reset mid-WAIT with client 1 owning, both held afterwards.
        go_to(200);
        req = 2'b10;
        exp_start(201, 2'b10, 3'd1);
        go_to(205);
        req = 2'b11;
        go_to(210);
        reset = 1'b1;
        exp_state(211, 2'b00, 3'd1, 1'b0);
        exp_start(212, 2'b01, 3'd0);
        go_to(211);
        reset = 1'b0;
        pulse_done(215, 2'b01);
        req = 2'b10;
        exp_start(219, 2'b10, 3'd1);
        pulse_done(222, 2'b10);
        req = 2'b00;
        exp_state(226, 2'b00, 3'd1, 1'b0);

        go_to(230);
        end_flag = 1'b1;
    end

endmodule
